display_update_arbiter: RTL and testbench

Arbitrates between two requesters (keyboard entry path and game logic) that want to change the character and check flag shown on screen, and drives the `character`/`check` inputs of the display controller. Updates commit only at the start of a frame (VSYNC falling edge), so a frame never shows a mix of old and new content. An optional minimum hold time keeps each message on screen for a fixed number of frames. Runs entirely in the pixel clock domain.

---
 rtl/display_update_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_display_update_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_update_arbiter.sv
// -----------------------------------------------------------------------------
// display_update_arbiter
//
// Arbitrates between two requesters (keyboard entry path and game logic) that
// want to change the character/check flag shown on screen. A granted update is
// committed to the display controller only at a frame start (VSYNC falling
// edge), so no frame ever shows a mix of old and new content. Arbitration is
// round-robin: the requester not granted last has priority.
//
// Optional feature (compile-time macro DISP_ARB_HOLD_EN):
//   defined     : after each commit the block sits in HOLD for HOLD_FRAMES
//                 frame starts before it will grant again.
//   not defined : the commit returns straight to IDLE; HOLD_FRAMES is only
//                 range-checked.
//
// Parameters:
//   HOLD_FRAMES  frames a committed update is held (1..255)
//
// Ports:
//   Pixelclock   in   pixel clock, all logic on rising edge
//   reset        in   asynchronous active-low reset
//   vsync        in   active-low VSYNC pulse, same clock domain
//   req0/req1    in   update request, held until ack or withdrawn
//   char0/char1  in   8-bit character code, sampled at grant
//   check0/1     in   check flag, sampled at grant
//   ack0/ack1    out  one-cycle pulse: that requester's update committed
//   character    out  registered character to the display controller
//   check        out  registered check flag to the display controller
//   busy         out  high whenever the state is not IDLE
// -----------------------------------------------------------------------------
module display_update_arbiter #(
   parameter int unsigned HOLD_FRAMES = 30
) (
   input  logic       Pixelclock,
   input  logic       reset,
   input  logic       vsync,
   input  logic       req0,
   input  logic [7:0] char0,
   input  logic       check0,
   output logic       ack0,
   input  logic       req1,
   input  logic [7:0] char1,
   input  logic       check1,
   output logic       ack1,
   output logic [7:0] character,
   output logic       check,
   output logic       busy
);

   // Elaboration-time guard on the hold length.
   if (HOLD_FRAMES < 1 || HOLD_FRAMES > 255) begin : g_hold_range
      $error("display_update_arbiter: HOLD_FRAMES must be in 1..255");
   end

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_WAIT_FRAME = 2'd1,
      S_HOLD       = 2'd2
   } state_e;

   state_e     state_q,      state_d;
   logic       vsync_q;
   logic       prio_q,       prio_d;        // 0: requester 0 has priority
   logic       grant_q,      grant_d;       // requester currently granted
   logic [7:0] pend_char_q,  pend_char_d;
   logic       pend_check_q, pend_check_d;
   logic [7:0] char_q,       char_d;
   logic       check_q,      check_d;
   logic       ack0_q,       ack0_d;
   logic       ack1_q,       ack1_d;
`ifdef DISP_ARB_HOLD_EN
   logic [7:0] hold_cnt_q,   hold_cnt_d;
`endif

   logic frame_start;
   logic req0_m;
   logic req1_m;
   logic win1;
   logic granted_req;

   assign frame_start = vsync_q & ~vsync;

   // A requester still seeing its ack this cycle has not had a chance to drop
   // req yet; masking it prevents an immediate duplicate grant.
   assign req0_m = req0 & ~ack0_q;
   assign req1_m = req1 & ~ack1_q;

   // Requester 1 wins when it is the only one asking, or both ask and it holds
   // priority.
   assign win1 = req1_m & (~req0_m | prio_q);

   assign granted_req = grant_q ? req1 : req0;

   // NOTE: every signal written here gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      prio_d       = prio_q;
      grant_d      = grant_q;
      pend_char_d  = pend_char_q;
      pend_check_d = pend_check_q;
      char_d       = char_q;
      check_d      = check_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
`ifdef DISP_ARB_HOLD_EN
      hold_cnt_d   = hold_cnt_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            // A frame_start in this same cycle is not used: the grant always
            // waits for a fresh frame start from WAIT_FRAME.
            if (req0_m || req1_m) begin
               grant_d      = win1;
               pend_char_d  = win1 ? char1  : char0;
               pend_check_d = win1 ? check1 : check0;
               state_d      = S_WAIT_FRAME;
            end
         end

         S_WAIT_FRAME: begin
            // Withdrawal wins over a coincident frame start.
            if (!granted_req) begin
               state_d = S_IDLE;
            end else if (frame_start) begin
               char_d  = pend_char_q;
               check_d = pend_check_q;
               ack0_d  = ~grant_q;
               ack1_d  = grant_q;
               // The requester not just served gets priority next time.
               prio_d  = ~grant_q;
`ifdef DISP_ARB_HOLD_EN
               hold_cnt_d = 8'd0;
               state_d    = S_HOLD;
`else
               state_d    = S_IDLE;
`endif
            end
         end

         S_HOLD: begin
`ifdef DISP_ARB_HOLD_EN
            if (frame_start) begin
               if (hold_cnt_q == 8'(HOLD_FRAMES - 1)) begin
                  state_d = S_IDLE;
               end else begin
                  hold_cnt_d = hold_cnt_q + 8'd1;
               end
            end
`else
            // Unreachable without the hold feature; recover to IDLE.
            state_d = S_IDLE;
`endif
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge Pixelclock or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         vsync_q      <= 1'b1;
         prio_q       <= 1'b0;
         grant_q      <= 1'b0;
         pend_char_q  <= 8'h00;
         pend_check_q <= 1'b0;
         char_q       <= 8'h00;
         check_q      <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         vsync_q      <= vsync;
         prio_q       <= prio_d;
         grant_q      <= grant_d;
         pend_char_q  <= pend_char_d;
         pend_check_q <= pend_check_d;
         char_q       <= char_d;
         check_q      <= check_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
      end
   end

`ifdef DISP_ARB_HOLD_EN
   always_ff @(posedge Pixelclock or negedge reset) begin
      if (!reset) begin
         hold_cnt_q <= 8'd0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
      end
   end
`endif

   assign character = char_q;
   assign check     = check_q;
   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_display_update_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for display_update_arbiter. A free-running VSYNC
// generator numbers frame starts; each accepted request pushes the expected
// commit (requester, data, frame number) into a scoreboard that a monitor
// pops whenever an ack appears. The monitor also tracks the displayed value
// every cycle. Works with DISP_ARB_HOLD_EN defined or not.
// -----------------------------------------------------------------------------
module tb_display_update_arbiter;

   localparam int HOLD       = 2;
   localparam int FRAME_CYC  = 20;
   localparam int VS_LOW     = 2;
   localparam int ACK_BUDGET = 8 * FRAME_CYC;
`ifdef DISP_ARB_HOLD_EN
   localparam int  GAP     = HOLD + 1;
   localparam bit  HOLD_ON = 1'b1;
`else
   localparam int  GAP     = 1;
   localparam bit  HOLD_ON = 1'b0;
`endif

   typedef struct {
      logic       who;
      logic [7:0] ch;
      logic       chk;
      int         frame;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       vsync;
   logic       req0, req1;
   logic [7:0] char0, char1;
   logic       check0, check1;
   logic       ack0_w, ack1_w;
   logic [7:0] char_w;
   logic       chk_w;
   logic       busy_w;

   exp_t       sb[$];
   int         fs_cnt;
   logic [7:0] mdl_char;
   logic       mdl_chk;
   int         n_vec;
   int         n_err;

   display_update_arbiter #(.HOLD_FRAMES(HOLD)) dut (
      .Pixelclock (clk),
      .reset      (rst_n),
      .vsync      (vsync),
      .req0       (req0),
      .char0      (char0),
      .check0     (check0),
      .ack0       (ack0_w),
      .req1       (req1),
      .char1      (char1),
      .check1     (check1),
      .ack1       (ack1_w),
      .character  (char_w),
      .check      (chk_w),
      .busy       (busy_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Inputs change 4 ns after the rising edge; the monitor samples at +2 ns.
   task automatic cycle();
      @(posedge clk);
      #4;
   endtask

   // VSYNC changes on falling edges; fs_cnt numbers the frame start that the
   // next rising edge will see.
   initial begin
      vsync  = 1'b1;
      fs_cnt = 0;
      forever begin
         repeat (FRAME_CYC - VS_LOW) @(negedge clk);
         vsync = 1'b0;
         fs_cnt++;
         repeat (VS_LOW) @(negedge clk);
         vsync = 1'b1;
      end
   end

   // Monitor: scoreboard pops on ack, displayed value checked every cycle.
   initial begin : monitor
      logic prev_ack;
      exp_t it;
      prev_ack = 1'b0;
      mdl_char = 8'h00;
      mdl_chk  = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (!rst_n) begin
            mdl_char = 8'h00;
            mdl_chk  = 1'b0;
         end else if (ack0_w || ack1_w) begin
            check("ack_onehot", 32'(ack0_w & ack1_w), 32'(0));
            check("ack_single_cycle", 32'(prev_ack), 32'(0));
            if (sb.size() == 0) begin
               check("unexpected_ack", 32'({ack1_w, ack0_w}), 32'(0));
            end else begin
               it = sb.pop_front();
               check("ack_who", 32'(ack1_w), 32'(it.who));
               check("commit_frame", 32'(fs_cnt), 32'(it.frame));
               mdl_char = it.ch;
               mdl_chk  = it.chk;
            end
         end
         check("character", 32'(char_w), 32'(mdl_char));
         check("check_flag", 32'(chk_w), 32'(mdl_chk));
         prev_ack = rst_n ? (ack0_w | ack1_w) : 1'b0;
      end
   end

   task automatic push(input logic who, input logic [7:0] ch, input logic chk,
                       input int frame);
      exp_t e;
      e.who   = who;
      e.ch    = ch;
      e.chk   = chk;
      e.frame = frame;
      sb.push_back(e);
   endtask

   task automatic idle_wait();
      int n;
      n = 0;
      while (busy_w !== 1'b0 && n < 10 * FRAME_CYC) begin
         cycle();
         n++;
      end
      if (n >= 10 * FRAME_CYC) check("idle_timeout", 32'(busy_w), 32'(0));
   endtask

   // Returns just after a frame start edge; base is that frame's number.
   task automatic align(output int base);
      int prev;
      int n;
      prev = fs_cnt;
      n    = 0;
      while (fs_cnt == prev && n < 2 * FRAME_CYC) begin
         cycle();
         n++;
      end
      base = fs_cnt;
   endtask

   // Waits for an ack, then drops that requester's req one cycle later.
   task automatic wait_ack(input string tag);
      int   n;
      logic who;
      n = 0;
      while (!(ack0_w || ack1_w) && n < ACK_BUDGET) begin
         cycle();
         n++;
      end
      if (n >= ACK_BUDGET) check({tag, "_timeout"}, 32'(ack0_w | ack1_w), 32'(1));
      who = ack1_w;
      cycle();
      if (who) req1 = 1'b0;
      else     req0 = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      sb.delete();
      repeat (cycles) cycle();
      rst_n = 1'b1;
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      int base;
      n_vec  = 0;
      n_err  = 0;
      rst_n  = 1'b0;
      req0   = 1'b0;
      req1   = 1'b0;
      char0  = 8'h00;
      char1  = 8'h00;
      check0 = 1'b0;
      check1 = 1'b0;

      // Reset held with random request activity.
      for (int i = 0; i < 5; i++) begin
         cycle();
         req0   = 1'($urandom_range(0, 1));
         req1   = 1'($urandom_range(0, 1));
         char0  = 8'($urandom);
         char1  = 8'($urandom);
         check0 = 1'($urandom_range(0, 1));
         check1 = 1'($urandom_range(0, 1));
         check("rst_ack0", 32'(ack0_w), 32'(0));
         check("rst_ack1", 32'(ack1_w), 32'(0));
         check("rst_busy", 32'(busy_w), 32'(0));
      end
      req0  = 1'b0;
      req1  = 1'b0;
      rst_n = 1'b1;
      repeat (2 * FRAME_CYC) cycle();
      check("idle_after_rst", 32'(busy_w), 32'(0));

      // Single request mid-frame; data changes after grant are ignored.
      idle_wait();
      align(base);
      repeat (3) cycle();
      req0 = 1'b1; char0 = 8'h41; check0 = 1'b1;
      push(1'b0, 8'h41, 1'b1, base + 1);
      repeat (2) cycle();
      check("single_granted", 32'(busy_w), 32'(1));
      char0 = 8'hEE; check0 = 1'b0;
      wait_ack("single_ack");
      check("single_busy_after", 32'(busy_w), 32'(HOLD_ON));

      // Contention right after reset: requester 0 first.
      idle_wait();
      cycle();
      do_reset(3);
      align(base);
      req0 = 1'b1; char0 = 8'h41; check0 = 1'b1;
      req1 = 1'b1; char1 = 8'h42; check1 = 1'b0;
      push(1'b0, 8'h41, 1'b1, base + 1);
      push(1'b1, 8'h42, 1'b0, base + 1 + GAP);
      wait_ack("cont_ack_a");
      wait_ack("cont_ack_b");

      // Withdrawal before the frame start, then a fresh request.
      idle_wait();
      align(base);
      req1 = 1'b1; char1 = 8'h55; check1 = 1'b1;
      repeat (2) cycle();
      check("wd_granted", 32'(busy_w), 32'(1));
      req1 = 1'b0;
      repeat (2) cycle();
      check("wd_cancelled", 32'(busy_w), 32'(0));
      req0 = 1'b1; char0 = 8'h30; check0 = 1'b0;
      push(1'b0, 8'h30, 1'b0, base + 1);
      wait_ack("wd_next_ack");

      // Request first seen on the frame-start edge waits a full frame.
      idle_wait();
      align(base);
      repeat (FRAME_CYC - 1) cycle();
      req1 = 1'b1; char1 = 8'h5A; check1 = 1'b0;
      push(1'b1, 8'h5A, 1'b0, base + 2);
      wait_ack("edge_ack");

      // Commit, then asynchronous reset during the hold window.
      idle_wait();
      align(base);
      req0 = 1'b1; char0 = 8'h66; check0 = 1'b1;
      push(1'b0, 8'h66, 1'b1, base + 1);
      wait_ack("rm_ack");
      repeat (2) cycle();
      rst_n = 1'b0;
      sb.delete();
      #1;
      check("async_rst_char", 32'(char_w), 32'(8'h00));
      check("async_rst_check", 32'(chk_w), 32'(0));
      check("async_rst_busy", 32'(busy_w), 32'(0));
      check("async_rst_acks", 32'({ack1_w, ack0_w}), 32'(0));
      repeat (3) cycle();
      rst_n = 1'b1;

      // In-flight grant dropped by reset: no ack may ever follow.
      align(base);
      req1 = 1'b1; char1 = 8'h99; check1 = 1'b1;
      repeat (3) cycle();
      rst_n = 1'b0;
      #1;
      check("inflight_rst_busy", 32'(busy_w), 32'(0));
      req1 = 1'b0;
      repeat (2) cycle();
      rst_n = 1'b1;

      // Priority back at requester 0 after reset.
      align(base);
      req0 = 1'b1; char0 = 8'h10; check0 = 1'b0;
      req1 = 1'b1; char1 = 8'h20; check1 = 1'b1;
      push(1'b0, 8'h10, 1'b0, base + 1);
      push(1'b1, 8'h20, 1'b1, base + 1 + GAP);
      wait_ack("prio_ack_a");
      wait_ack("prio_ack_b");

      idle_wait();
      repeat (FRAME_CYC) cycle();
      check("sb_drained", 32'(sb.size()), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
